// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the PC and loads the IF/ID pipeline register.
// A BOOT/RUN/HALT sequencer handles stall, branch redirect and the halt instruction.
module fetch_pc_stage #(
  parameter int unsigned     WL         = 5,
  parameter int unsigned     IW         = 32,
  parameter logic [WL-1:0]   RESET_PC   = '0,
  parameter logic [IW-1:0]   HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [WL-1:0] branch_target,
  input  logic [WL-1:0] seq_pc,
  input  logic [IW-1:0] instr_in,
  output logic [WL-1:0] pc,
  output logic [IW-1:0] instr_d,
  output logic [WL-1:0] pc_plus_d,
  output logic          valid_d,
  output logic          halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [WL-1:0] pc_q, pc_d;
  logic [IW-1:0] ifid_instr_q, ifid_instr_d;
  logic [WL-1:0] ifid_pc_plus_q, ifid_pc_plus_d;
  logic          ifid_valid_q, ifid_valid_d;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pc_plus_d = ifid_pc_plus_q;
    ifid_valid_d   = ifid_valid_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (branch_taken) begin
          pc_d           = branch_target;
          ifid_instr_d   = '0;
          ifid_pc_plus_d = '0;
          ifid_valid_d   = 1'b0;
        end else if (!stall) begin
          ifid_instr_d   = instr_in;
          ifid_pc_plus_d = seq_pc;
          ifid_valid_d   = 1'b1;
          // The halt instruction itself is delivered, but the PC stops on it.
          if (instr_in == HALT_INSTR) begin
            state_d = ST_HALT;
          end else begin
            pc_d = seq_pc;
          end
        end
      end

      ST_HALT: begin
        if (branch_taken) begin
          pc_d           = branch_target;
          ifid_instr_d   = '0;
          ifid_pc_plus_d = '0;
          ifid_valid_d   = 1'b0;
          state_d        = ST_RUN;
        end else if (!stall) begin
          ifid_instr_d   = '0;
          ifid_pc_plus_d = '0;
          ifid_valid_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_PC;
      ifid_instr_q   <= '0;
      ifid_pc_plus_q <= '0;
      ifid_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc_plus_q <= ifid_pc_plus_d;
      ifid_valid_q   <= ifid_valid_d;
    end
  end

  assign pc        = pc_q;
  assign instr_d   = ifid_instr_q;
  assign pc_plus_d = ifid_pc_plus_q;
  assign valid_d   = ifid_valid_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_pc_stage.sv
module tb_fetch_pc_stage;

  localparam int          WL   = 5;
  localparam int          IW   = 32;
  localparam int          NPC  = 32;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [WL-1:0] branch_target = '0;
  logic [WL-1:0] seq_pc;
  logic [IW-1:0] instr_in;
  logic [WL-1:0] pc;
  logic [IW-1:0] instr_d;
  logic [WL-1:0] pc_plus_d;
  logic          valid_d;
  logic          halted;

  logic [IW-1:0] imem [NPC];

  fetch_pc_stage #(
    .WL(WL), .IW(IW), .RESET_PC(5'd0), .HALT_INSTR(HALT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .seq_pc(seq_pc), .instr_in(instr_in),
    .pc(pc), .instr_d(instr_d), .pc_plus_d(pc_plus_d), .valid_d(valid_d),
    .halted(halted)
  );

  assign seq_pc   = pc + 5'd1;
  assign instr_in = imem[pc];

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WL-1:0] pc;
    logic [IW-1:0] instr;
    logic [WL-1:0] plus;
    logic          valid;
    logic          halted;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int          m_pc;
  logic [31:0] m_instr;
  int          m_plus;
  bit          m_valid;
  bit          m_halt;
  bit          m_boot;

  function automatic obs_t model_obs();
    obs_t o;
    o.pc     = WL'(m_pc);
    o.instr  = m_instr;
    o.plus   = WL'(m_plus);
    o.valid  = m_valid;
    o.halted = m_halt;
    return o;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_plus = 0; m_valid = 0; m_halt = 0; m_boot = 1;
  endtask

  task automatic apply(input bit st, input bit br, input int tgt);
    stall         = st;
    branch_taken  = br;
    branch_target = WL'(tgt);
    if (m_boot) begin
      m_boot = 0;
    end else if (br) begin
      m_pc = tgt % NPC; m_instr = 0; m_plus = 0; m_valid = 0; m_halt = 0;
    end else if (st) begin
    end else if (m_halt) begin
      m_instr = 0; m_plus = 0; m_valid = 0;
    end else begin
      m_instr = imem[m_pc];
      m_plus  = (m_pc + 1) % NPC;
      m_valid = 1;
      if (imem[m_pc] == HALT) m_halt = 1;
      else                    m_pc = m_plus;
    end
    sb_q.push_back(model_obs());
  endtask

  task automatic step(input bit st, input bit br, input int tgt);
    @(negedge clk);
    apply(st, br, tgt);
  endtask

  task automatic do_reset(input int hold, input bit br, input int tgt);
    @(negedge clk);
    model_reset();
    sb_q.push_back(model_obs());
    sb_q.push_back(model_obs());
    rst_n = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      sb_q.push_back(model_obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, br, tgt);
  endtask

  initial begin
    obs_t e, g;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = '{pc: pc, instr: instr_d, plus: pc_plus_d, valid: valid_d, halted: halted};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL ifid_state #%0d t=%0t: got pc=%0d instr=%h plus=%0d valid=%0b halted=%0b, expected pc=%0d instr=%h plus=%0d valid=%0b halted=%0b",
                   checks, $time, g.pc, g.instr, g.plus, g.valid, g.halted,
                   e.pc, e.instr, e.plus, e.valid, e.halted);
        end else begin
          $display("check #%0d t=%0t ok: pc=%0d instr=%h plus=%0d valid=%0b halted=%0b",
                   checks, $time, g.pc, g.instr, g.plus, g.valid, g.halted);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < NPC; i++) begin
      v = $urandom;
      if (v == HALT) v = 32'h0;
      imem[i] = v;
    end
    imem[9] = HALT;
    model_reset();

    @(negedge clk);
    sb_q.push_back(model_obs());
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b1, 15);
    repeat (7) step(1'b0, 1'b0, 0);

    do_reset(1, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 0);

    step(1'b0, 1'b1, 30);
    repeat (3) step(1'b0, 1'b0, 0);

    step(1'b0, 1'b1, 4);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    step(1'b0, 1'b1, 6);
    step(1'b1, 1'b1, 20);
    step(1'b0, 1'b0, 0);

    step(1'b0, 1'b1, 9);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    step(1'b0, 1'b1, 8);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 0);

    imem[17] = HALT;
    imem[25] = HALT;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50)
        do_reset($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, NPC - 1));
      else
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, NPC - 1));
    end

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d predictions never observed", sb_q.size());
    end else begin
      $display("check scoreboard ok: all predictions observed");
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL coverage: only %0d checks performed", checks);
    end else begin
      $display("check coverage ok: %0d checks performed", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
